// File: rtl/spart_buffered.sv
// spart_buffered: bus-mapped UART with TX/RX FIFOs, configurable frame width,
// optional even parity, programmable baud divisor and sticky receive error flags.
module spart_buffered #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          PARITY_EN  = 1'b0,
    parameter logic [15:0] DIV_RST    = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rxd,
    output logic       txd,
    output logic       rda,
    output logic       tbr
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    // Bus decode
    logic wr_en, rd_en;
    assign wr_en = iocs & ~iorw;
    assign rd_en = iocs & iorw;

    // Divisor; bit period never shorter than two clocks
    logic [15:0] div, period;
    assign period = (div < 16'd2) ? 16'd2 : div;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_W-1:0] tx_head;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign tx_push  = wr_en && (ioaddr == 2'b00) && !tx_full;
    assign rx_pop   = rd_en && (ioaddr == 2'b00) && !rx_empty;

    // TX state
    tx_state_t         tx_state, tx_state_n;
    logic [15:0]       tx_cnt, tx_cnt_n;
    logic [BW-1:0]     tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic              tx_par, tx_par_n, txd_n, tx_load, tx_idle;

    // RX state
    rx_state_t         rx_state, rx_state_n;
    logic [15:0]       rx_cnt, rx_cnt_n;
    logic [BW-1:0]     rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_sh, rx_sh_n;
    logic              rx_par, rx_par_n;
    logic              rx_s1, rx_sync, rx_prev;
    logic              rx_push_req, par_err_set, frame_err_set, overrun_set;

    logic [2:0] flags, flags_set, flags_clr;
    logic [7:0] rd_data;

    // Next frame is loaded from IDLE or straight out of a finished stop bit
    assign tx_load = !tx_empty &&
                     ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0)));
    assign tx_pop  = tx_load;
    assign tx_idle = (tx_state == TX_IDLE) && tx_empty;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        txd_n      = txd;
        if (tx_state != TX_IDLE) begin
            if (tx_cnt != '0) begin
                tx_cnt_n = tx_cnt - 16'd1;
            end else begin
                tx_cnt_n = period - 16'd1;
                case (tx_state)
                    TX_START: begin
                        tx_state_n = TX_DATA;
                        tx_bit_n   = '0;
                        txd_n      = tx_sh[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == BW'(DATA_W - 1)) begin
                            if (PARITY_EN) begin
                                tx_state_n = TX_PAR;
                                txd_n      = tx_par;
                            end else begin
                                tx_state_n = TX_STOP;
                                txd_n      = 1'b1;
                            end
                        end else begin
                            tx_sh_n  = tx_sh >> 1;
                            txd_n    = tx_sh[1];
                            tx_bit_n = tx_bit + BW'(1);
                        end
                    end
                    TX_PAR: begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end
                    default: begin
                        tx_state_n = TX_IDLE;
                        txd_n      = 1'b1;
                    end
                endcase
            end
        end
        if (tx_load) begin
            tx_state_n = TX_START;
            tx_cnt_n   = period - 16'd1;
            tx_sh_n    = tx_head;
            tx_par_n   = ^tx_head;
            txd_n      = 1'b0;
        end
    end

    // RX: start detected on synchronised falling edge, sampled mid-bit
    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt;
        rx_bit_n      = rx_bit;
        rx_sh_n       = rx_sh;
        rx_par_n      = rx_par;
        rx_push_req   = 1'b0;
        par_err_set   = 1'b0;
        frame_err_set = 1'b0;
        if ((rx_state != RX_IDLE) && (rx_cnt != '0)) begin
            rx_cnt_n = rx_cnt - 16'd1;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state_n = RX_START;
                        rx_cnt_n   = (period >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    rx_cnt_n = period - 16'd1;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = '0;
                    end
                end
                RX_DATA: begin
                    rx_cnt_n = period - 16'd1;
                    rx_sh_n  = {rx_sync, rx_sh[DATA_W-1:1]};
                    if (rx_bit == BW'(DATA_W - 1)) begin
                        rx_state_n = PARITY_EN ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + BW'(1);
                    end
                end
                RX_PAR: begin
                    rx_cnt_n   = period - 16'd1;
                    rx_par_n   = rx_sync;
                    rx_state_n = RX_STOP;
                end
                default: begin
                    rx_state_n = RX_IDLE;
                    if (rx_sync) begin
                        rx_push_req = 1'b1;
                        par_err_set = PARITY_EN && (rx_par != ^rx_sh);
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            endcase
        end
    end

    // A full RX FIFO still accepts a byte when the bus pops in the same cycle
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign overrun_set = rx_push_req && rx_full && !rx_pop;
    assign flags_set   = {par_err_set, frame_err_set, overrun_set};
    assign flags_clr   = (wr_en && (ioaddr == 2'b01)) ? databus[5:3] : 3'b000;

    assign rda = !rx_empty;
    assign tbr = !tx_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            flags    <= '0;
            div      <= DIV_RST;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            txd      <= txd_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_par   <= rx_par_n;
            rx_s1    <= rxd;
            rx_sync  <= rx_s1;
            rx_prev  <= rx_sync;
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
            flags <= (flags & ~flags_clr) | flags_set;
            if (wr_en && (ioaddr == 2'b10)) div[7:0]  <= databus;
            if (wr_en && (ioaddr == 2'b11)) div[15:8] <= databus;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= databus[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // Combinational read mux; empty RX FIFO reads as zero
    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            2'b00:   if (!rx_empty) rd_data = 8'(rx_mem[rx_rp[AW-1:0]]);
            2'b01:   rd_data = {2'b00, flags, tx_idle, tbr, rda};
            2'b10:   rd_data = div[7:0];
            default: rd_data = div[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : 8'bz;

endmodule
